fifo_flags: RTL

Parametrised synchronous FIFO that succeeds the basic fifo block. Adds an occupancy count, programmable almost-full and almost-empty thresholds, and a selectable read mode (first-word-fall-through or registered). Adds sticky overflow and underflow error flags, and defines behaviour for a read and a write in the same cycle at the full and empty boundaries. Sits between the UART rx/tx datapaths and the interface FSM as a drop-in buffer.

---
 rtl/fifo_flags.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// selectable FWFT or registered read, and sticky overflow/underflow flags.
module fifo_flags #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = 2**W - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] write_data,
    input  logic         rd,
    output logic [B-1:0] read_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam int          DEPTH = 2**W;
    localparam logic [W:0]  FULL_COUNT = DEPTH[W:0];
    localparam logic [W:0]  AF_L = AF_LEVEL[W:0];
    localparam logic [W:0]  AE_L = AE_LEVEL[W:0];

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("fifo_flags: AF_LEVEL out of range 1..2**W");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $error("fifo_flags: AE_LEVEL out of range 0..2**W-1");
    end
    if (B < 1 || W < 1) begin : g_bad_size
        $error("fifo_flags: B and W must be at least 1");
    end

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W:0]   count_q;
    logic         rd_acc;
    logic         wr_acc;

    // Handshake: wr/rd are single-cycle requests sampled on the rising edge.
    // A read is taken only when not empty; a write is taken when not full, or
    // when full but a read is taken on the same edge (the freed slot is reused).
    // Rejected requests are dropped and recorded in the sticky error flags.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_COUNT);
    assign almost_empty = (count_q <= AE_L);
    assign almost_full  = (count_q >= AF_L);

    // Storage is not reset; contents behind the pointers are meaningless after reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[w_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + W'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (W+1)'(1);
                2'b01:   count_q <= count_q - (W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Setting an error flag wins over clearing it on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & ~wr_acc) | (overflow & ~clr_err);
            underflow <= (rd & empty)   | (underflow & ~clr_err);
        end
    end

    if (FWFT) begin : g_fwft
        assign read_data = mem[r_ptr];
    end else begin : g_registered
        logic [B-1:0] read_q;

        // Loaded from the old slot contents, so a same-edge write to r_ptr is not seen.
        always_ff @(posedge clk) begin
            if (reset) begin
                read_q <= '0;
            end else if (rd_acc) begin
                read_q <= mem[r_ptr];
            end
        end
        assign read_data = read_q;
    end

endmodule
